// File: rtl/dest_ip_filter_regs_pkg.sv
// ---------------------------------------------------------------------------
// dest_ip_filter_regs_pkg
//   Shared register-map definitions for the destination-IP filter register
//   block: word offsets, FSM state encoding, STATUS bit positions and the
//   fixed response patterns used for busy and timeout replies.
// ---------------------------------------------------------------------------
package dest_ip_filter_regs_pkg;

  // Word offsets inside the block (reg_addr[1:0])
  localparam logic [1:0] OFF_ENTRY_IP      = 2'd0;
  localparam logic [1:0] OFF_ENTRY_RD_ADDR = 2'd1;
  localparam logic [1:0] OFF_ENTRY_WR_ADDR = 2'd2;
  localparam logic [1:0] OFF_STATUS        = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } filter_state_e;

  // STATUS register bit positions
  localparam int STATUS_TIMEOUT_BIT = 0;
  localparam int STATUS_BUSY_BIT    = 1;

  // Data returned for a hit that arrives while a table access is in flight
  localparam logic [31:0] BUSY_DATA    = 32'hDEAD_BEEF;
  // Data returned when a table access is abandoned by the timeout
  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Assemble the zero-extended STATUS word from its flags
  function automatic logic [31:0] status_word(input logic timeout, input logic busy_err);
    logic [31:0] w;
    w                     = '0;
    w[STATUS_TIMEOUT_BIT] = timeout;
    w[STATUS_BUSY_BIT]    = busy_err;
    return w;
  endfunction

endpackage

// File: rtl/dest_ip_filter_regs.sv
// ---------------------------------------------------------------------------
// dest_ip_filter_regs
//   Register-ring slave giving software access to the destination-IP filter
//   table. Four words live behind BLOCK_TAG:
//     0 ENTRY_IP      (R/W) data staged for / returned from the table
//     1 ENTRY_RD_ADDR (R/W) writing it launches a table read
//     2 ENTRY_WR_ADDR (R/W) writing it launches a table write of ENTRY_IP
//     3 STATUS        (RO, clear-on-read) [0] timeout, [1] busy_err
//   Words not addressed to this block are forwarded with one cycle latency.
//
// Ports
//   clk, reset (async, active-low)
//   reg_*_in  / reg_*_out            : register ring in / out
//   dest_ip_filter_rd_{addr,req,ip,ack} : table read handshake
//   dest_ip_filter_wr_{addr,req,ip,ack} : table write handshake
//
// Build option
//   DEST_IP_FILTER_TIMEOUT_EN : when defined, a table access that is not
//   acknowledged within TIMEOUT cycles is abandoned and answered with
//   32'hFFFF_FFFF, setting STATUS[0]. Otherwise the wait is unbounded.
// ---------------------------------------------------------------------------
module dest_ip_filter_regs
  import dest_ip_filter_regs_pkg::*;
#(
  parameter int                        LUT_DEPTH      = 32,
  parameter int                        LUT_DEPTH_BITS = 5,
  parameter int                        REG_ADDR_WIDTH = 23,
  parameter logic [REG_ADDR_WIDTH-3:0] BLOCK_TAG      = '0,
  parameter int                        TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      reg_req_in,
  input  logic                      reg_ack_in,
  input  logic                      reg_rd_wr_L_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
  input  logic [31:0]               reg_data_in,
  input  logic [1:0]                reg_src_in,

  output logic                      reg_req_out,
  output logic                      reg_ack_out,
  output logic                      reg_rd_wr_L_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_out,
  output logic [31:0]               reg_data_out,
  output logic [1:0]                reg_src_out,

  output logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_rd_addr,
  output logic                      dest_ip_filter_rd_req,
  input  logic [31:0]               dest_ip_filter_rd_ip,
  input  logic                      dest_ip_filter_rd_ack,

  output logic [LUT_DEPTH_BITS-1:0] dest_ip_filter_wr_addr,
  output logic                      dest_ip_filter_wr_req,
  output logic [31:0]               dest_ip_filter_wr_ip,
  input  logic                      dest_ip_filter_wr_ack
);

  // LUT_DEPTH is descriptive only: table indices are LUT_DEPTH_BITS wide and
  // oversized software addresses simply wrap. TIMEOUT is only consumed when
  // the timeout option is built in.
  logic unused_params;
  assign unused_params = ^{LUT_DEPTH[0], TIMEOUT[0]};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  filter_state_e             state_q;
  logic [31:0]               ip_q;
  logic [LUT_DEPTH_BITS-1:0] rd_addr_q;
  logic [LUT_DEPTH_BITS-1:0] wr_addr_q;
  logic                      status_timeout_q;
  logic                      status_busy_q;
  logic                      rd_req_q;
  logic                      wr_req_q;

  // The ring write that launched the table access, replayed as its ack
  logic [REG_ADDR_WIDTH-1:0] hold_addr_q;
  logic [31:0]               hold_data_q;
  logic [1:0]                hold_src_q;
  logic                      resp_sent_q;

  // Registered ring outputs (also the pass-through pipeline stage)
  logic                      reg_req_out_q;
  logic                      reg_ack_out_q;
  logic                      reg_rd_wr_L_out_q;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_out_q;
  logic [31:0]               reg_data_out_q;
  logic [1:0]                reg_src_out_q;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic        hit;
  logic [1:0]  offset;
  logic        waiting;
  logic        table_ack;
  logic        tmo_expired;
  logic        wait_done;
  logic [31:0] rd_value;
  logic [31:0] resp_data;

  // A word already acked by another block is not ours to answer
  assign hit     = reg_req_in && !reg_ack_in &&
                   (reg_addr_in[REG_ADDR_WIDTH-1:2] == BLOCK_TAG);
  assign offset  = reg_addr_in[1:0];
  assign waiting = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);

  // Acks from the table only count in the matching wait state
  assign table_ack = ((state_q == ST_RD_WAIT) && dest_ip_filter_rd_ack) ||
                     ((state_q == ST_WR_WAIT) && dest_ip_filter_wr_ack);

`ifdef DEST_IP_FILTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_q;
  assign tmo_expired = waiting && (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_expired = 1'b0;
`endif

  assign wait_done = waiting && (table_ack || tmo_expired);
  // An ack arriving on the expiry cycle wins over the timeout
  assign resp_data = table_ack ? hold_data_q : TIMEOUT_DATA;

  always_comb begin
    rd_value = '0;
    case (offset)
      OFF_ENTRY_IP:      rd_value = ip_q;
      OFF_ENTRY_RD_ADDR: rd_value = 32'(rd_addr_q);
      OFF_ENTRY_WR_ADDR: rd_value = 32'(wr_addr_q);
      default:           rd_value = status_word(status_timeout_q, status_busy_q);
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      ip_q              <= '0;
      rd_addr_q         <= '0;
      wr_addr_q         <= '0;
      status_timeout_q  <= 1'b0;
      status_busy_q     <= 1'b0;
      rd_req_q          <= 1'b0;
      wr_req_q          <= 1'b0;
      hold_addr_q       <= '0;
      hold_data_q       <= '0;
      hold_src_q        <= '0;
      resp_sent_q       <= 1'b0;
      reg_req_out_q     <= 1'b0;
      reg_ack_out_q     <= 1'b0;
      reg_rd_wr_L_out_q <= 1'b0;
      reg_addr_out_q    <= '0;
      reg_data_out_q    <= '0;
      reg_src_out_q     <= '0;
`ifdef DEST_IP_FILTER_TIMEOUT_EN
      tmo_cnt_q         <= '0;
`endif
    end else begin
      // Default: forward the incoming ring word one cycle later
      reg_req_out_q     <= reg_req_in;
      reg_ack_out_q     <= reg_ack_in;
      reg_rd_wr_L_out_q <= reg_rd_wr_L_in;
      reg_addr_out_q    <= reg_addr_in;
      reg_data_out_q    <= reg_data_in;
      reg_src_out_q     <= reg_src_in;
      rd_req_q          <= 1'b0;
      wr_req_q          <= 1'b0;

`ifdef DEST_IP_FILTER_TIMEOUT_EN
      if (waiting && !wait_done) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end else begin
        tmo_cnt_q <= '0;
      end
`endif

      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            reg_ack_out_q <= 1'b1;
            if (reg_rd_wr_L_in) begin
              reg_data_out_q <= rd_value;
              if (offset == OFF_STATUS) begin
                status_timeout_q <= 1'b0;
                status_busy_q    <= 1'b0;
              end
            end else begin
              case (offset)
                OFF_ENTRY_IP: begin
                  ip_q <= reg_data_in;
                end
                OFF_ENTRY_RD_ADDR, OFF_ENTRY_WR_ADDR: begin
                  // Park the request; it is answered once the table acks
                  hold_addr_q       <= reg_addr_in;
                  hold_data_q       <= reg_data_in;
                  hold_src_q        <= reg_src_in;
                  reg_req_out_q     <= 1'b0;
                  reg_ack_out_q     <= 1'b0;
                  reg_rd_wr_L_out_q <= 1'b0;
                  reg_addr_out_q    <= '0;
                  reg_data_out_q    <= '0;
                  reg_src_out_q     <= '0;
                  if (offset == OFF_ENTRY_RD_ADDR) begin
                    rd_addr_q <= reg_data_in[LUT_DEPTH_BITS-1:0];
                    rd_req_q  <= 1'b1;
                    state_q   <= ST_RD_WAIT;
                  end else begin
                    wr_addr_q <= reg_data_in[LUT_DEPTH_BITS-1:0];
                    wr_req_q  <= 1'b1;
                    state_q   <= ST_WR_WAIT;
                  end
                end
                default: begin
                  // STATUS is read-only: acked, no effect
                end
              endcase
            end
          end
        end

        ST_RD_WAIT, ST_WR_WAIT: begin
          if (hit) begin
            reg_ack_out_q  <= 1'b1;
            reg_data_out_q <= BUSY_DATA;
            status_busy_q  <= 1'b1;
          end
          if (wait_done) begin
            state_q <= ST_RESP;
            if ((state_q == ST_RD_WAIT) && table_ack) begin
              ip_q <= dest_ip_filter_rd_ip;
            end
            if (!table_ack) begin
              status_timeout_q <= 1'b1;
              hold_data_q      <= TIMEOUT_DATA;
            end
            // Answer now if the ring slot is free, otherwise from RESP
            if (!reg_req_in) begin
              reg_req_out_q     <= 1'b1;
              reg_ack_out_q     <= 1'b1;
              reg_rd_wr_L_out_q <= 1'b0;
              reg_addr_out_q    <= hold_addr_q;
              reg_data_out_q    <= resp_data;
              reg_src_out_q     <= hold_src_q;
              resp_sent_q       <= 1'b1;
            end else begin
              resp_sent_q       <= 1'b0;
            end
          end
        end

        ST_RESP: begin
          if (hit) begin
            reg_ack_out_q  <= 1'b1;
            reg_data_out_q <= BUSY_DATA;
            status_busy_q  <= 1'b1;
          end
          if (resp_sent_q) begin
            state_q <= ST_IDLE;
          end else if (!reg_req_in) begin
            reg_req_out_q     <= 1'b1;
            reg_ack_out_q     <= 1'b1;
            reg_rd_wr_L_out_q <= 1'b0;
            reg_addr_out_q    <= hold_addr_q;
            reg_data_out_q    <= hold_data_q;
            reg_src_out_q     <= hold_src_q;
            resp_sent_q       <= 1'b1;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign reg_req_out            = reg_req_out_q;
  assign reg_ack_out            = reg_ack_out_q;
  assign reg_rd_wr_L_out        = reg_rd_wr_L_out_q;
  assign reg_addr_out           = reg_addr_out_q;
  assign reg_data_out           = reg_data_out_q;
  assign reg_src_out            = reg_src_out_q;

  assign dest_ip_filter_rd_addr = rd_addr_q;
  assign dest_ip_filter_rd_req  = rd_req_q;
  assign dest_ip_filter_wr_addr = wr_addr_q;
  assign dest_ip_filter_wr_req  = wr_req_q;
  assign dest_ip_filter_wr_ip   = ip_q;

endmodule

// File: doc/dest_ip_filter_regs.md
DEST_IP_FILTER_REGS -- requirements
Module: dest_ip_filter_regs

Interface
REQ-001 Parameters SHALL be: LUT_DEPTH, 32, number of filter table entries; LUT_DEPTH_BITS, 5, table address width; REG_ADDR_WIDTH, 23, register-ring word address width; BLOCK_TAG, 21'h0, the block's address tag (REG_ADDR_WIDTH-2 bits); TIMEOUT, 255, maximum number of cycles to wait for a table ack.
REQ-002 Ports SHALL be: clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-003 Register ring in: reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each; reg_addr_in  in  REG_ADDR_WIDTH; reg_data_in  in  32; reg_src_in  in  2.
REQ-004 Register ring out: reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each; reg_addr_out  out  REG_ADDR_WIDTH; reg_data_out  out  32; reg_src_out  out  2.
REQ-005 Table read port: dest_ip_filter_rd_addr  out  LUT_DEPTH_BITS; dest_ip_filter_rd_req  out  1; dest_ip_filter_rd_ip  in  32; dest_ip_filter_rd_ack  in  1.
REQ-006 Table write port: dest_ip_filter_wr_addr  out  LUT_DEPTH_BITS; dest_ip_filter_wr_req  out  1; dest_ip_filter_wr_ip  out  32; dest_ip_filter_wr_ack  in  1.

Function
REQ-007 A request SHALL hit when reg_req_in=1 and reg_addr_in[REG_ADDR_WIDTH-1:2]==BLOCK_TAG; offsets SHALL be 0 ENTRY_IP (R/W), 1 ENTRY_RD_ADDR (R/W), 2 ENTRY_WR_ADDR (R/W), 3 STATUS (RO, clear-on-read).
REQ-008 Non-hit ring words SHALL pass to the outputs with exactly 1 cycle latency, unmodified.
REQ-009 The FSM SHALL have the states IDLE, RD_WAIT, WR_WAIT, and RESP.
REQ-010 IDLE, hit, read of any offset SHALL cause the next cycle to emit reg_req_out=1, reg_ack_out=1, and reg_data_out=the register value (STATUS zero-extended); the STATUS read SHALL clear it in the same cycle.
REQ-011 IDLE, hit, write to offset 0 SHALL load the ip register, with the ack emitted next cycle.
REQ-012 IDLE, hit, write to offset 1 SHALL latch rd_addr=data[LUT_DEPTH_BITS-1:0], pulse dest_ip_filter_rd_req for exactly 1 cycle, and go to RD_WAIT.
REQ-013 In RD_WAIT, rd_ack=1 SHALL capture rd_ip into the ip register and go to RESP.
REQ-014 IDLE, hit, write to offset 2 SHALL latch wr_addr, drive wr_ip=ip register, pulse wr_req for exactly 1 cycle, and go to WR_WAIT; in WR_WAIT, wr_ack=1 SHALL go to RESP.
REQ-015 RESP SHALL emit the held request with reg_ack_out=1 for 1 cycle, then go to IDLE.
REQ-016 rd_req and wr_req SHALL never be high simultaneously.
REQ-017 A hit arriving when the FSM is not in IDLE SHALL be emitted next cycle with ack=1 and data=32'hDEAD_BEEF, and SHALL set STATUS[1] (busy_err).
REQ-018 A hit arriving with reg_ack_in=1 already set SHALL be passed through untouched.
REQ-019 Addresses wider than LUT_DEPTH_BITS SHALL be truncated; no range error SHALL be raised.

Reset
REQ-020 reset=0 SHALL force the FSM to IDLE, clear all ring outputs, rd_req/wr_req, addresses, ip, STATUS, and the timeout counter to 0, immediately and asynchronously.
REQ-021 An in-flight table access SHALL be abandoned without an ack; a table ack arriving after reset release SHALL be ignored in IDLE.

Configuration
REQ-022 With DEST_IP_FILTER_TIMEOUT_EN defined, an 8-bit counter SHALL run in RD_WAIT/WR_WAIT; when TIMEOUT cycles pass without an ack, the FSM SHALL go to RESP, the ack SHALL carry data 32'hFFFF_FFFF, and STATUS[0] (timeout) SHALL be set.
REQ-023 Without DEST_IP_FILTER_TIMEOUT_EN, the WAIT states SHALL wait indefinitely and STATUS[0] SHALL read 0.

Structure
REQ-024 Offsets, the FSM state encoding, STATUS bit positions, and the 32'hDEAD_BEEF/32'hFFFF_FFFF constants SHALL live in the shared router register package.
REQ-025 The design SHALL be a single module with no sub-module; the ring pass-through pipeline register SHALL be inline.

Verification
REQ-026 Write 0xC0A80001 to ENTRY_IP, write 3 to ENTRY_WR_ADDR, ack after 2 cycles -> wr_req pulses once with wr_addr=3 and wr_ip=0xC0A80001, and the ring ack is emitted 1 cycle after wr_ack.
REQ-027 Write 5 to ENTRY_RD_ADDR, responder returns 0x0A000001 with ack -> a subsequent ENTRY_IP read returns 0x0A000001.
REQ-028 A non-hit address with tag BLOCK_TAG+1 -> output is identical 1 cycle later, and no table request is made.
REQ-029 A hit arrives while in WR_WAIT -> data 0xDEADBEEF is returned; a STATUS read returns 0x2, and a second STATUS read returns 0x0.
REQ-030 With DEST_IP_FILTER_TIMEOUT_EN, no rd_ack -> ack with 0xFFFFFFFF after 255 cycles, and STATUS=0x1.
REQ-031 reset asserted during RD_WAIT, then a late rd_ack -> all outputs read 0, the FSM is in IDLE, and no ring ack is produced.
